operand_fetch: RTL and testbench
================================

# operand_fetch

Decode/operand-fetch stage that sits directly upstream of the ALU. It accepts 32-bit instruction words, reads a 16×32 register file, and builds the ALU `opsel`, A and B operands. It stalls on read-after-write and write-after-write hazards using a pending-write scoreboard. The writeback port updates the register file, and results are forwarded to same-cycle readers.

## Interface
Parameters:
- `NREGS`, 16: register count; register index width is log2(`NREGS`) = 4.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  an instruction word is offered.
- `in_ready`  out  1  the stage accepts the offered word this cycle.
- `in_iword`  in  32  instruction word.
- `wb_en`  in  1  writeback strobe.
- `wb_rd`  in  4  writeback destination register.
- `wb_data`  in  32  writeback value.
- `flush`  in  1  discard the held output and any word offered this cycle.
- `out_valid`  out  1  the output register holds an issued op.
- `out_ready`  in  1  the ALU stage consumes the op.
- `out_opsel`  out  6  ALU opcode.
- `out_a`  out  32  operand A.
- `out_b`  out  32  operand B.
- `out_rd`  out  4  destination register.
- `out_wr`  out  1  the op writes `out_rd`.
- `out_illegal`  out  1  the word's class field is unrecognised.

## Operation
Instruction fields:
- `cls` = iword[31:28]
- `fn` = iword[27:24]
- `rd` = [23:20]
- `rs1` = [19:16]
- `rs2` = [15:12]
- `imm` = [15:0]

Class decode:
- 0x0 ALU-R: B = R[rs2].
- 0x8 ALU-I: B = sext(imm).
- 0x2 CMP-R: B = R[rs2].
- 0xA CMP-I: B = sext(imm).
- Any other class: `out_illegal`=1, `out_wr`=0, B = sext(imm), and only `rs1` counts as used.

Decode rules:
- `opsel` = {1'b0, cls[1], fn}. ALU classes therefore produce 0x00–0x0F (ADD 0x00, SUB 0x01, AND 0x04, OR 0x05, XOR 0x06, MVHI 0x0B, NAND 0x0C, NOR 0x0D, XNOR 0x0E). CMP classes produce 0x10–0x1F (F 0x10 … GTZ 0x1F).
- A = R[rs1] for every class.
- `out_wr` = 1 for the four legal classes.
- sext is arithmetic sign extension of bit 15 to 32 bits. MVHI's shift is performed in the ALU, not here.

Register file and forwarding:
- Reads are combinational at accept time.
- If `wb_en` is high and `wb_rd` equals a read index, `wb_data` is forwarded to that read.
- Writes occur on the clock edge when `wb_en` is high.

Scoreboard:
- `pend[NREGS-1:0]`: bit r is set when an op with `out_wr`=1 and `out_rd`=r leaves the output register (`out_valid & out_ready`).
- Bit r is cleared when `wb_en` is high with `wb_rd`=r.
- If a set and a clear hit the same bit in the same cycle, the set wins.

Hazard, evaluated for each used source index s and for `rd` when the new op writes:
- hz(s) = (pend[s] & ~(wb_en & wb_rd==s)) | (out_valid & out_wr & out_rd==s).
- `stall` = OR of hz over used sources, plus hz(rd) when the new op writes (WAW).

Handshake:
- `in_ready` = ~stall & (~out_valid | out_ready) & ~flush.
- On accept, the output register loads the decoded op and `out_valid` is set. `out_valid` clears on `out_ready` unless a new op is accepted in the same cycle.
- Output payload is held stable while `out_valid & ~out_ready`.

Flush:
- Clears `out_valid` and blocks acceptance that cycle.
- The scoreboard and register file are unaffected.

## Timing
- Accept-to-`out_valid` latency is 1 cycle. Throughput is 1 op/cycle when hazard-free and `out_ready`=1.
- A dependent op following a writing op stalls until that op's writeback cycle. It issues in the cycle `wb_en` hits its source, using the forwarded value.
- Reset values:
  - `out_valid`, `out_wr`, `out_illegal` = 0.
  - `out_opsel`, `out_rd` = 0; `out_a`, `out_b` = 0.
  - `pend` = 0; all registers = 0.
  - `in_ready` = 1 once reset deasserts, subject to `flush`.
- Reset asserted mid-stream drops the held op immediately (asynchronously).
- `flush` and `wb_en` in the same cycle: the writeback still commits and clears its `pend` bit.
- Under `out_valid & ~out_ready`, no new op is accepted even if hazard-free.

## Structure
- Shared package (`cpu_pkg`) holds:
  - Class codes (`CLS_ALUR`, `CLS_ALUI`, `CLS_CMPR`, `CLS_CMPI`).
  - The `opsel` constants used by the ALU.
  - Field bit positions.
- One sub-module, `regfile_2r1w` (2 read ports, 1 write port, same-cycle write forwarding, asynchronous clear). The scoreboard and the output register stay in the top.

## Test plan
- ALU-R: R1=5, R2=−1, iword 0x0_0_3_1_2000 (ADD, rd3, rs1, rs2) -> next cycle `out_valid`=1, `opsel`=0x00, A=5, B=0xFFFFFFFF, `out_rd`=3, `out_wr`=1.
- CMP-I LT: cls 0xA, fn 2, imm 0x8000 -> `opsel`=0x12, B=0xFFFF8000.
- RAW stall: issue ADD rd3, then ADD rs1=3 -> `in_ready`=0 until `wb_en`, `wb_rd`=3, `wb_data`=10; in that cycle the op is accepted and next cycle A=10.
- WAW plus simultaneous set/clear: a second writer of rd3 stalls until the first writeback. A set of `pend[3]` coinciding with its clear leaves `pend[3]`=1.
- Backpressure: hold `out_ready`=0 for 3 cycles -> output payload unchanged and `in_ready`=0. `flush` then gives `out_valid`=0 next cycle and `pend` unchanged.
- Reset mid-stream with `out_valid`=1 -> `out_valid`=0 immediately and register reads return 0. An illegal class 0x3 gives `out_illegal`=1 and `out_wr`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, class codes and ALU opsel values.
// Imported by the operand-fetch stage and its bus interface.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 4;
    localparam int ILEN    = 32;

    localparam int FIELD_W = 4;
    localparam int IMM_W   = 16;
    localparam int CLS_LSB = 28;
    localparam int FN_LSB  = 24;
    localparam int RD_LSB  = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_LSB = 12;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        CLS_ALUR = 4'h0,
        CLS_CMPR = 4'h2,
        CLS_ALUI = 4'h8,
        CLS_CMPI = 4'hA
    } cls_e;

    localparam logic [5:0] OP_ADD     = 6'h00;
    localparam logic [5:0] OP_SUB     = 6'h01;
    localparam logic [5:0] OP_AND     = 6'h04;
    localparam logic [5:0] OP_OR      = 6'h05;
    localparam logic [5:0] OP_XOR     = 6'h06;
    localparam logic [5:0] OP_MVHI    = 6'h0B;
    localparam logic [5:0] OP_NAND    = 6'h0C;
    localparam logic [5:0] OP_NOR     = 6'h0D;
    localparam logic [5:0] OP_XNOR    = 6'h0E;
    localparam logic [5:0] OP_CMP_F   = 6'h10;
    localparam logic [5:0] OP_CMP_LT  = 6'h12;
    localparam logic [5:0] OP_CMP_GTZ = 6'h1F;

    function automatic logic is_legal(input logic [3:0] cls);
        return cls inside {CLS_ALUR, CLS_CMPR, CLS_ALUI, CLS_CMPI};
    endfunction

    function automatic logic uses_rs2(input logic [3:0] cls);
        return (cls == CLS_ALUR) || (cls == CLS_CMPR);
    endfunction

    // Class bit 1 separates the compare bank (0x10-0x1F) from the ALU bank.
    function automatic logic [5:0] make_opsel(input logic is_cmp, input logic [3:0] fn);
        return {1'b0, is_cmp, fn};
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle for the operand-fetch stage: instruction input, writeback port,
// flush and the issued-op output towards the ALU.
interface operand_fetch_if #(
    parameter int DW = cpu_pkg::XLEN,
    parameter int AW = cpu_pkg::REG_AW
);
    logic                     in_valid;
    logic                     in_ready;
    logic [cpu_pkg::ILEN-1:0] in_iword;
    logic                     wb_en;
    logic [AW-1:0]            wb_rd;
    logic [DW-1:0]            wb_data;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [5:0]               out_opsel;
    logic [DW-1:0]            out_a;
    logic [DW-1:0]            out_b;
    logic [AW-1:0]            out_rd;
    logic                     out_wr;
    logic                     out_illegal;

    modport slave (
        input  in_valid, in_iword, wb_en, wb_rd, wb_data, flush, out_ready,
        output in_ready, out_valid, out_opsel, out_a, out_b, out_rd, out_wr, out_illegal
    );

    modport master (
        output in_valid, in_iword, wb_en, wb_rd, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_opsel, out_a, out_b, out_rd, out_wr, out_illegal
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with same-cycle write-to-read forwarding
// and asynchronous clear of every entry.
module regfile_2r1w #(
    parameter int NREGS = 16,
    parameter int DW    = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [NREGS];

    // NOTE: this array is reset on purpose (registers must read 0 after reset),
    // which keeps it in flops; drop the reset branch if it should map to RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
    assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: decodes the instruction, reads operands with writeback
// forwarding, stalls on RAW/WAW hazards via a pending-write scoreboard, and holds one issued op.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           reset,
    operand_fetch_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [FIELD_W-1:0] cls;
    logic [FIELD_W-1:0] fn;
    logic [AW-1:0]      rd_idx;
    logic [AW-1:0]      rs1_idx;
    logic [AW-1:0]      rs2_idx;
    logic [IMM_W-1:0]   imm;
    logic               legal;
    logic               rs2_used;
    logic [DW-1:0]      rdata_a;
    logic [DW-1:0]      rdata_b;
    logic [DW-1:0]      imm_sext;

    logic [NREGS-1:0]   hz;
    logic               stall;
    logic               in_ready;
    logic               accept;

    logic               out_valid_q,   out_valid_d;
    logic [5:0]         out_opsel_q,   out_opsel_d;
    logic [DW-1:0]      out_a_q,       out_a_d;
    logic [DW-1:0]      out_b_q,       out_b_d;
    logic [AW-1:0]      out_rd_q,      out_rd_d;
    logic               out_wr_q,      out_wr_d;
    logic               out_illegal_q, out_illegal_d;
    logic [NREGS-1:0]   pend_q,        pend_d;
    logic [NREGS-1:0]   pend_set;
    logic [NREGS-1:0]   pend_clr;

    assign cls      = bus.in_iword[CLS_LSB +: FIELD_W];
    assign fn       = bus.in_iword[FN_LSB  +: FIELD_W];
    assign rd_idx   = bus.in_iword[RD_LSB  +: AW];
    assign rs1_idx  = bus.in_iword[RS1_LSB +: AW];
    assign rs2_idx  = bus.in_iword[RS2_LSB +: AW];
    assign imm      = bus.in_iword[IMM_LSB +: IMM_W];
    assign legal    = is_legal(cls);
    assign rs2_used = uses_rs2(cls);
    assign imm_sext = {{(DW-IMM_W){imm[IMM_W-1]}}, imm};

    regfile_2r1w #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (AW)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (bus.wb_en),
        .waddr_i   (bus.wb_rd),
        .wdata_i   (bus.wb_data),
        .raddr_a_i (rs1_idx),
        .rdata_a_o (rdata_a),
        .raddr_b_i (rs2_idx),
        .rdata_b_o (rdata_b)
    );

    // A register is busy while its write is still outstanding (unless it retires this
    // cycle) or while the op sitting in the output register is about to write it.
    always_comb begin
        hz = '0;
        for (int r = 0; r < NREGS; r++) begin
            hz[r] = (pend_q[r] & ~(bus.wb_en & (bus.wb_rd == AW'(r))))
                  | (out_valid_q & out_wr_q & (out_rd_q == AW'(r)));
        end
    end

    assign stall    = hz[rs1_idx] | (rs2_used & hz[rs2_idx]) | (legal & hz[rd_idx]);
    assign in_ready = ~stall & (~out_valid_q | bus.out_ready) & ~bus.flush;
    assign accept   = bus.in_valid & in_ready;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_opsel_d   = out_opsel_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_rd_d      = out_rd_q;
        out_wr_d      = out_wr_q;
        out_illegal_d = out_illegal_q;
        pend_set      = '0;
        pend_clr      = '0;

        if (accept) begin
            out_valid_d   = 1'b1;
            out_opsel_d   = make_opsel(cls[1], fn);
            out_a_d       = rdata_a;
            out_b_d       = rs2_used ? rdata_b : imm_sext;
            out_rd_d      = rd_idx;
            out_wr_d      = legal;
            out_illegal_d = ~legal;
        end else if (bus.flush || bus.out_ready) begin
            out_valid_d   = 1'b0;
        end

        if (out_valid_q && bus.out_ready && out_wr_q) begin
            pend_set[out_rd_q] = 1'b1;
        end
        if (bus.wb_en) begin
            pend_clr[bus.wb_rd] = 1'b1;
        end
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs; the combinational block above uses blocking ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_opsel_q   <= '0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_rd_q      <= '0;
            out_wr_q      <= 1'b0;
            out_illegal_q <= 1'b0;
            pend_q        <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_opsel_q   <= out_opsel_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_rd_q      <= out_rd_d;
            out_wr_q      <= out_wr_d;
            out_illegal_q <= out_illegal_d;
            pend_q        <= pend_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_opsel   = out_opsel_q;
    assign bus.out_a       = out_a_q;
    assign bus.out_b       = out_b_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_wr      = out_wr_q;
    assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic, with a reference
// model feeding an expected-op queue that an independent monitor drains.
module tb_operand_fetch;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  opsel;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic        wr;
        logic        illegal;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference state: architectural registers, outstanding writes, and the held op.
    logic [31:0] m_regs [16];
    bit          m_pend [16];
    bit          m_held;
    bit          m_held_wr;
    logic [3:0]  m_held_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
        m_held    = 1'b0;
        m_held_wr = 1'b0;
        m_held_rd = '0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] rd_fwd(input logic [3:0] r, input logic we,
                                           input logic [3:0] wr, input logic [31:0] wd);
        return (we && wr == r) ? wd : m_regs[r];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] iw, input logic we,
                                          input logic [3:0] wr, input logic [31:0] wd);
        exp_t        e;
        logic [3:0]  cls;
        logic [31:0] simm;
        cls     = iw[31:28];
        simm    = {{16{iw[15]}}, iw[15:0]};
        e.opsel = {1'b0, cls[1], iw[27:24]};
        e.rd    = iw[23:20];
        e.a     = rd_fwd(iw[19:16], we, wr, wd);
        case (cls)
            4'h0, 4'h2: begin e.b = rd_fwd(iw[15:12], we, wr, wd); e.wr = 1'b1; e.illegal = 1'b0; end
            4'h8, 4'hA: begin e.b = simm; e.wr = 1'b1; e.illegal = 1'b0; end
            default:    begin e.b = simm; e.wr = 1'b0; e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic bit busy(input logic [3:0] s, input logic we, input logic [3:0] wr);
        return (m_pend[s] && !(we && wr == s)) || (m_held && m_held_wr && m_held_rd == s);
    endfunction

    function automatic bit model_stall(input logic [31:0] iw, input logic we, input logic [3:0] wr);
        logic [3:0] cls;
        bit         legal;
        bit         two_src;
        cls     = iw[31:28];
        legal   = (cls == 4'h0) || (cls == 4'h2) || (cls == 4'h8) || (cls == 4'hA);
        two_src = (cls == 4'h0) || (cls == 4'h2);
        return busy(iw[19:16], we, wr) || (two_src && busy(iw[15:12], we, wr))
            || (legal && busy(iw[23:20], we, wr));
    endfunction

    // One clock cycle: drive inputs, check handshake against the model, advance the model.
    task automatic step(input logic v, input logic [31:0] iw, input logic we, input logic [3:0] wr,
                        input logic [31:0] wd, input logic fl, input logic ordy);
        logic exp_rdy;
        logic acc;
        logic consumed;
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_iword  = iw;
        bus.wb_en     = we;
        bus.wb_rd     = wr;
        bus.wb_data   = wd;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
        exp_rdy = !model_stall(iw, we, wr) && (!m_held || ordy) && !fl;
        check("in_ready", bus.in_ready, exp_rdy);
        check("out_valid", bus.out_valid, m_held);
        acc = v && exp_rdy;
        e   = model_decode(iw, we, wr, wd);
        if (acc) exp_q.push_back(e);
        consumed = m_held && ordy;
        if (we) m_pend[wr] = 1'b0;
        if (consumed && m_held_wr) m_pend[m_held_rd] = 1'b1;
        if (we) m_regs[wr] = wd;
        if (acc) begin
            m_held    = 1'b1;
            m_held_wr = e.wr;
            m_held_rd = e.rd;
        end else if (consumed || fl) begin
            m_held = 1'b0;
        end
    endtask

    task automatic idle(input logic we, input logic [3:0] wr, input logic [31:0] wd, input logic ordy);
        step(1'b0, 32'h0, we, wr, wd, 1'b0, ordy);
    endtask

    task automatic chk_out(input string tag, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] rd, input logic wr, input logic ill);
        check({tag, "_valid"},   bus.out_valid, 1'b1);
        check({tag, "_opsel"},   bus.out_opsel, op);
        check({tag, "_a"},       bus.out_a, a);
        check({tag, "_b"},       bus.out_b, b);
        check({tag, "_rd"},      bus.out_rd, rd);
        check({tag, "_wr"},      bus.out_wr, wr);
        check({tag, "_illegal"}, bus.out_illegal, ill);
    endtask

    // Monitor: compares the presented op with the queue head every cycle it is valid,
    // and retires the head when the op is consumed or flushed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b0 && bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_op", bus.out_valid, 1'b0);
                end else begin
                    e = exp_q[0];
                    check("mon_opsel",   bus.out_opsel, e.opsel);
                    check("mon_a",       bus.out_a, e.a);
                    check("mon_b",       bus.out_b, e.b);
                    check("mon_rd",      bus.out_rd, e.rd);
                    check("mon_wr",      bus.out_wr, e.wr);
                    check("mon_illegal", bus.out_illegal, e.illegal);
                    if (bus.out_ready || bus.flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [31:0] iw;
        logic [3:0]  cls;
        logic        we;
        logic [3:0]  wr;
        logic        fl;
        logic [3:0]  pend_list[$];

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_iword  = '0;
        bus.wb_en     = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid",   bus.out_valid, 1'b0);
        check("rst_out_wr",      bus.out_wr, 1'b0);
        check("rst_out_illegal", bus.out_illegal, 1'b0);
        check("rst_out_opsel",   bus.out_opsel, 6'h00);
        check("rst_out_rd",      bus.out_rd, 4'h0);
        check("rst_out_a",       bus.out_a, 32'h0);
        check("rst_out_b",       bus.out_b, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);

        // ALU-R ADD rd3 = R1 + R2 with R1=5, R2=-1
        idle(1'b1, 4'd1, 32'd5, 1'b1);
        idle(1'b1, 4'd2, 32'hFFFF_FFFF, 1'b1);
        step(1'b1, 32'h0031_2000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(1'b0, 4'd0, 32'd0, 1'b0);
        chk_out("alur", 6'h00, 32'd5, 32'hFFFF_FFFF, 4'd3, 1'b1, 1'b0);

        // RAW on r3: stalls until the writeback of 10, issuing with the forwarded value
        step(1'b1, 32'h0043_0000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        check("raw_stall_held", bus.in_ready, 1'b0);
        step(1'b1, 32'h0043_0000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        check("raw_stall_pend", bus.in_ready, 1'b0);
        step(1'b1, 32'h0043_0000, 1'b1, 4'd3, 32'd10, 1'b0, 1'b1);
        check("raw_issue", bus.in_ready, 1'b1);
        idle(1'b0, 4'd0, 32'd0, 1'b0);
        chk_out("raw", 6'h00, 32'd10, 32'd0, 4'd4, 1'b1, 1'b0);

        // WAW on r4
        step(1'b1, 32'h0045_0000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        check("waw_stall_held", bus.in_ready, 1'b0);
        step(1'b1, 32'h0045_0000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        check("waw_stall_pend", bus.in_ready, 1'b0);
        step(1'b1, 32'h0045_0000, 1'b1, 4'd4, 32'd77, 1'b0, 1'b1);
        check("waw_issue", bus.in_ready, 1'b1);
        idle(1'b0, 4'd0, 32'd0, 1'b0);

        // Set and clear of pend[4] in the same cycle: the set survives
        idle(1'b1, 4'd4, 32'd55, 1'b1);
        step(1'b1, 32'h0054_0000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        check("set_wins_stall", bus.in_ready, 1'b0);
        step(1'b1, 32'h0054_0000, 1'b1, 4'd4, 32'h1234, 1'b0, 1'b1);
        check("set_wins_release", bus.in_ready, 1'b1);
        idle(1'b0, 4'd0, 32'd0, 1'b1);

        // Backpressure for 3 cycles, then flush
        step(1'b1, 32'h0171_2000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0086_0000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
            check("bp_in_ready", bus.in_ready, 1'b0);
            chk_out("bp_hold", 6'h01, 32'd5, 32'hFFFF_FFFF, 4'd7, 1'b1, 1'b0);
        end
        step(1'b1, 32'h0086_0000, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        check("flush_in_ready", bus.in_ready, 1'b0);
        idle(1'b0, 4'd0, 32'd0, 1'b0);
        check("flush_out_valid", bus.out_valid, 1'b0);
        step(1'b1, 32'h0097_0000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        check("flush_no_pend7", bus.in_ready, 1'b1);

        // Illegal class 0x3, then CMP-I LT with a negative immediate
        step(1'b1, 32'h3A1F_8001, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(1'b0, 4'd0, 32'd0, 1'b0);
        chk_out("illegal", 6'h1A, 32'd0, 32'hFFFF_8001, 4'd1, 1'b0, 1'b1);
        step(1'b1, 32'hA261_8000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(1'b0, 4'd0, 32'd0, 1'b0);
        chk_out("cmpi_lt", 6'h12, 32'd5, 32'hFFFF_8000, 4'd6, 1'b1, 1'b0);

        // Reset mid-stream while an op is held
        reset = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 32'h0031_0000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        idle(1'b0, 4'd0, 32'd0, 1'b0);
        check("midrst_reg_clear", bus.out_a, 32'd0);

        // Random traffic over registers 0..7 so hazards are frequent
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 4))
                0:       cls = 4'h0;
                1:       cls = 4'h8;
                2:       cls = 4'h2;
                3:       cls = 4'hA;
                default: cls = 4'($urandom_range(0, 15));
            endcase
            r      = $urandom();
            iw     = {cls, r[27:0]};
            iw[23] = 1'b0;
            iw[19] = 1'b0;
            pend_list.delete();
            for (int k = 0; k < 16; k++) if (m_pend[k]) pend_list.push_back(4'(k));
            we = ($urandom_range(0, 9) < 4);
            if (pend_list.size() > 0 && $urandom_range(0, 3) != 0)
                wr = pend_list[$urandom_range(0, pend_list.size() - 1)];
            else
                wr = 4'($urandom_range(0, 7));
            fl = ($urandom_range(0, 19) == 0);
            step(($urandom_range(0, 9) < 8), iw, we, wr, $urandom(), fl,
                 fl ? 1'b0 : ($urandom_range(0, 9) < 7));
        end

        repeat (4) idle(1'b0, 4'd0, 32'd0, 1'b1);
        @(negedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
